mdu_hilo_writer: RTL and testbench
==================================

Name: mdu_hilo_writer

Overview:
- Multi-cycle multiply/divide unit; the producer side of the HI/LO register write port.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and computes the result iteratively.
- Drives we_hi/we_lo/hi/lo with a one-cycle write strobe.
- Exposes busy so the pipeline stalls later HI/LO consumers.

Parameters:
DATA_W, 32, operand/result width; HI and LO are DATA_W each.

Ports:
clk  input  1  system clock, posedge active
rst  input  1  asynchronous, active-low reset
start  input  1  op request, sampled on posedge only while IDLE
op  input  3  operation code (package encoding)
src_a  input  DATA_W  rs operand / dividend / MTHI-MTLO data
src_b  input  DATA_W  rt operand / divisor
cancel  input  1  pipeline flush; aborts in-flight op
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
we_hi  output  1  HI write enable, one-cycle pulse
we_lo  output  1  LO write enable, one-cycle pulse
hi  output  DATA_W  HI write data
lo  output  DATA_W  LO write data

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, done, we_hi, we_lo = 0; hi, lo = 0; counter and accumulators = 0. Reset mid-operation discards the op and produces no write.
- States:
  - IDLE: accepts requests.
  - MUL: iterative shift-add.
  - DIV: restoring radix-2.
  - DONE: write cycle.
- All outputs are registered.
- IDLE with start=1, cancel=0 and a legal op:
  - MTHI/MTLO: go to DONE next edge; hi (or lo) = src_a; only the matching write enable asserts.
  - MULT/MULTU/DIV/DIVU: latch operands. Signed ops latch magnitudes plus sign flags. Load counter=DATA_W-1 and enter MUL or DIV.
- MUL/DIV run exactly DATA_W iteration cycles: one bit per cycle, counter decrements, leave at counter==0.
  - Transition to DONE applies sign correction.
  - Product is 2*DATA_W bits: hi = upper half, lo = lower half.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Quotient goes to lo, remainder to hi.
- Latency: start sampled at edge T gives done/we_* high during the cycle after edge T+DATA_W+1 (33 cycles for DATA_W=32). MTHI/MTLO: high during the cycle after edge T+1.
- DONE lasts exactly one cycle.
  - done=1.
  - we_hi and we_lo are both 1 for MUL/DIV ops; only one of them is 1 for MTHI/MTLO.
  - Returns to IDLE; busy drops with done.
  - hi/lo hold their values after DONE until the next write.
- start is ignored while busy. Illegal op codes (6, 7) are ignored: no state change, no done.
- Division by zero: skips iteration; DONE next cycle with lo=all-ones, hi=src_a (defined result for verification).
- Signed DIV of most-negative by -1: lo=0x80000000, hi=0. The magnitude path must produce this without overflow handling.
- cancel:
  - In MUL/DIV: next edge returns to IDLE, no done, no write.
  - Same cycle as start: start is ignored.
  - In DONE: no effect; the write already presented completes.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle combinational DATA_W x DATA_W multiply and go IDLE -> DONE directly (done at cycle T+1, same timing as MTHI). DIV is unchanged.
- Undefined: iterative 32-cycle multiply as above; no hardware multiplier is inferred.

Decomposition:
- Package mdu_pkg holds:
  - op encoding: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - state encoding: IDLE, MUL, DIV, DONE;
  - DIV0 result constants.
- One natural sub-module: mdu_div_iter, a restoring divider datapath (remainder/quotient shift registers and one subtract-compare per cycle), controlled by the parent FSM.
- Multiply stays in the parent.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> after 33 cycles done=1, we_hi=we_lo=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=0x0000000E, hi=0x00000002; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU src_a=0x12345678, src_b=0 -> done one cycle after start, lo=0xFFFFFFFF, hi=0x12345678.
- MTHI src_a=0xDEADBEEF -> next cycle we_hi=1, we_lo=0, hi=0xDEADBEEF, done=1; a start asserted while busy during a DIV -> ignored, exactly one done.
- DIV started then cancel at iteration 10 -> busy falls next cycle, done/we never assert; a new MULTU 3*5 then gives lo=15, hi=0.
- rst low at iteration 20 of MULT -> all outputs 0 immediately; after release, idle with no write pulse; with MDU_FAST_MUL_EN, MULT 6*7 -> lo=42 one cycle after start.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and divide-by-zero constants for the MDU
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // Divide by zero yields an all-ones quotient; the remainder is the raw dividend.
    localparam logic MDU_DIV0_LO_BIT = 1'b1;

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - restoring radix-2 divider datapath, one quotient bit per step
module mdu_div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quo_nxt_o,
    output logic [DATA_W-1:0] rem_nxt_o
);

    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              fits;

    // Remainder stays below the divisor, so the low DATA_W bits of the difference are exact.
    assign shifted   = {rem_q, quo_q[DATA_W-1]};
    assign fits      = shifted >= {1'b0, dvs_q};
    assign diff      = shifted[DATA_W-1:0] - dvs_q;
    assign rem_nxt_o = fits ? diff : shifted[DATA_W-1:0];
    assign quo_nxt_o = {quo_q[DATA_W-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_nxt_o;
            quo_q <= quo_nxt_o;
        end
    end

endmodule

// File: rtl/mdu_hilo_writer.sv
// rtl/mdu_hilo_writer.sv - multi-cycle multiply/divide unit driving the HI/LO write port
// Build option MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU instead of shift-add.
module mdu_hilo_writer
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic              we_hi,
    output logic              we_lo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d, sign_a_q, sign_a_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic                res_whi_q, res_whi_d, res_wlo_q, res_wlo_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                we_hi_q, we_hi_d, we_lo_q, we_lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic                signed_op, a_neg, b_neg, accept;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic                div_load, div_step;
    logic [DATA_W-1:0]   quo_nxt, rem_nxt;

    assign signed_op = mdu_is_signed(op);
    assign a_neg     = signed_op & src_a[DATA_W-1];
    assign b_neg     = signed_op & src_b[DATA_W-1];
    assign a_mag     = a_neg ? (-src_a) : src_a;
    assign b_mag     = b_neg ? (-src_b) : src_b;
    assign accept    = start && !cancel && !busy_q && (state_q == IDLE);

    // Shift-add: multiplier sits in the low half of prod_q and is consumed LSB first.
    assign mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, (prod_q[0] ? mcand_q : {DATA_W{1'b0}})};
    assign mul_next = {mul_sum, prod_q[DATA_W-1:1]};

`ifdef MDU_FAST_MUL_EN
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{DATA_W{a_neg}}, src_a};
    assign ext_b     = {{DATA_W{b_neg}}, src_b};
    assign fast_prod = ext_a * ext_b;
`endif

    mdu_div_iter #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quo_nxt_o  (quo_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        sign_a_d  = sign_a_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        res_whi_d = res_whi_q;
        res_wlo_d = res_wlo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        we_hi_d   = 1'b0;
        we_lo_d   = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_MTHI: begin
                            res_hi_d  = src_a;
                            res_whi_d = 1'b1;
                            res_wlo_d = 1'b0;
                            state_d   = DONE;
                        end
                        MDU_MTLO: begin
                            res_lo_d  = src_a;
                            res_whi_d = 1'b0;
                            res_wlo_d = 1'b1;
                            state_d   = DONE;
                        end
                        MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                            {res_hi_d, res_lo_d} = fast_prod;
                            res_whi_d = 1'b1;
                            res_wlo_d = 1'b1;
                            state_d   = DONE;
`else
                            mcand_d = a_mag;
                            prod_d  = {{DATA_W{1'b0}}, b_mag};
                            sign_d  = a_neg ^ b_neg;
                            cnt_d   = CNT_W'(DATA_W - 1);
                            state_d = MUL;
`endif
                        end
                        MDU_DIV, MDU_DIVU: begin
                            res_whi_d = 1'b1;
                            res_wlo_d = 1'b1;
                            if (src_b == '0) begin
                                res_lo_d = {DATA_W{MDU_DIV0_LO_BIT}};
                                res_hi_d = src_a;
                                state_d  = DONE;
                            end else begin
                                div_load = 1'b1;
                                sign_d   = a_neg ^ b_neg;
                                sign_a_d = a_neg;
                                cnt_d    = CNT_W'(DATA_W - 1);
                                state_d  = DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        {res_hi_d, res_lo_d} = sign_q ? (-mul_next) : mul_next;
                        res_whi_d = 1'b1;
                        res_wlo_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DIV: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        res_lo_d = sign_q ? (-quo_nxt) : quo_nxt;
                        res_hi_d = sign_a_q ? (-rem_nxt) : rem_nxt;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                we_hi_d = res_whi_q;
                we_lo_d = res_wlo_q;
                if (res_whi_q) hi_d = res_hi_q;
                if (res_wlo_q) lo_d = res_lo_q;
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs lag the FSM by one cycle, so busy also covers the write cycle.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            sign_a_q  <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            res_whi_q <= 1'b0;
            res_wlo_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_hi_q   <= 1'b0;
            we_lo_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            sign_a_q  <= sign_a_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            res_whi_q <= res_whi_d;
            res_wlo_q <= res_wlo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_hi_q   <= we_hi_d;
            we_lo_q   <= we_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign we_hi = we_hi_q;
    assign we_lo = we_lo_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// tb/tb_mdu_hilo_writer.sv - scoreboard bench for mdu_hilo_writer
module tb_mdu_hilo_writer;
    import mdu_pkg::*;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         rst_n, start, cancel;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, we_hi, we_lo;
    logic [W-1:0] hi, lo;

    mdu_hilo_writer #(.DATA_W(W)) dut (
        .clk    (clk),
        .rst    (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .we_hi  (we_hi),
        .we_lo  (we_lo),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         whi;
        logic         wlo;
        int           lat;
    } vec_t;

    typedef struct {
        logic         we_hi;
        logic         we_lo;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    logic         o_done, o_whi, o_wlo;
    logic [W-1:0] o_hi, o_lo;
    int           o_lat;

    task automatic pulse_start(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        o_lat = 0;
        o_done = 1'b0;
        while (!o_done && o_lat < 100) begin
            @(posedge clk);
            #1;
            o_lat++;
            o_done = done;
        end
        o_whi = we_hi; o_wlo = we_lo; o_hi = hi; o_lo = lo;
    endtask

    task automatic drive_and_wait(input vec_t v);
        exp_t e;
        e.we_hi = v.whi;
        e.we_lo = v.wlo;
        e.hi    = v.whi ? v.hi : model_hi;
        e.lo    = v.wlo ? v.lo : model_lo;
        e.lat   = v.lat;
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        pulse_start(v.op, v.a, v.b);
        wait_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, we_hi, we_lo, hi, lo} !== '0)
            $display("FAIL reset_outputs got %h want 0", {busy, done, we_hi, we_lo, hi, lo});
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_release_idle got %b want 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_mul_div();
        vec_t tv[10];
        exp_t e;
        tv[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1, MUL_LAT};
        tv[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b1, MUL_LAT};
        tv[2] = '{MDU_MULT,  32'd6,        32'd7,        32'h00000000, 32'd42,       1'b1, 1'b1, MUL_LAT};
        tv[3] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 1'b1, MUL_LAT};
        tv[4] = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 1'b1, MUL_LAT};
        tv[5] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b1, DIV_LAT};
        tv[6] = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b1, 1'b1, DIV_LAT};
        tv[7] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b1, DIV_LAT};
        tv[8] = '{MDU_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, 1};
        tv[9] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1'b1, DIV_LAT};
        for (int i = 0; i < 10; i++) begin
            drive_and_wait(tv[i]);
            e = sb.pop_front();
            total_cnt++;
            if (o_lat !== e.lat) $display("FAIL vec%0d_latency got %0d want %0d", i, o_lat, e.lat);
            else pass_cnt++;
            total_cnt++;
            if ({o_done, o_whi, o_wlo} !== {1'b1, e.we_hi, e.we_lo})
                $display("FAIL vec%0d_strobes got %b want %b", i, {o_done, o_whi, o_wlo}, {1'b1, e.we_hi, e.we_lo});
            else pass_cnt++;
            total_cnt++;
            if ({o_hi, o_lo} !== {e.hi, e.lo})
                $display("FAIL vec%0d_hilo got %h want %h", i, {o_hi, o_lo}, {e.hi, e.lo});
            else pass_cnt++;
        end
    endtask

    task automatic test_mthi_busy();
        vec_t v;
        exp_t e;
        int   ndone = 0;
        int   first = 0;
        logic [W-1:0] f_hi = '0;
        logic [W-1:0] f_lo = '0;
        v = '{MDU_MTHI, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1};
        drive_and_wait(v);
        e = sb.pop_front();
        total_cnt++;
        if (o_lat !== e.lat) $display("FAIL mthi_latency got %0d want %0d", o_lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if ({o_done, o_whi, o_wlo} !== {1'b1, e.we_hi, e.we_lo})
            $display("FAIL mthi_strobes got %b want %b", {o_done, o_whi, o_wlo}, {1'b1, e.we_hi, e.we_lo});
        else pass_cnt++;
        total_cnt++;
        if ({o_hi, o_lo} !== {e.hi, e.lo}) $display("FAIL mthi_hilo got %h want %h", {o_hi, o_lo}, {e.hi, e.lo});
        else pass_cnt++;

        // DIVU 1000/7 with an MTLO request pulsed while the divide is busy
        pulse_start(MDU_DIVU, 32'd1000, 32'd7);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) begin start = 1'b1; op = MDU_MTLO; src_a = 32'hA5A5A5A5; end
            if (c == 7) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin first = c; f_hi = hi; f_lo = lo; end
            end
        end
        model_hi = 32'd6;
        model_lo = 32'd142;
        total_cnt++;
        if (ndone !== 1) $display("FAIL busy_start_done_count got %0d want 1", ndone);
        else pass_cnt++;
        total_cnt++;
        if (first !== DIV_LAT) $display("FAIL busy_start_latency got %0d want %0d", first, DIV_LAT);
        else pass_cnt++;
        total_cnt++;
        if ({f_hi, f_lo} !== {model_hi, model_lo})
            $display("FAIL busy_start_hilo got %h want %h", {f_hi, f_lo}, {model_hi, model_lo});
        else pass_cnt++;
    endtask

    task automatic test_illegal_hold();
        int seen = 0;
        pulse_start(3'd6, 32'h11111111, 32'h22222222);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL illegal_op_busy got %b want 0", busy);
        else pass_cnt++;
        pulse_start(3'd7, 32'h33333333, 32'h44444444);
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || we_hi || we_lo || busy) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL illegal_op_activity got %0d want 0", seen);
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== {model_hi, model_lo}) $display("FAIL hilo_hold got %h want %h", {hi, lo}, {model_hi, model_lo});
        else pass_cnt++;
    endtask

    task automatic test_cancel();
        vec_t v;
        exp_t e;
        int   seen = 0;
        pulse_start(MDU_DIVU, 32'h00001000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk) cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL cancel_busy got %b want 0", busy);
        else pass_cnt++;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || we_hi || we_lo) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL cancel_no_write got %0d want 0", seen);
        else pass_cnt++;
        v = '{MDU_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 1'b1, 1'b1, MUL_LAT};
        drive_and_wait(v);
        e = sb.pop_front();
        total_cnt++;
        if ({o_done, o_lat} !== {1'b1, e.lat}) $display("FAIL after_cancel_done got %0d/%0d want 1/%0d", o_done, o_lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if ({o_hi, o_lo} !== {e.hi, e.lo}) $display("FAIL after_cancel_hilo got %h want %h", {o_hi, o_lo}, {e.hi, e.lo});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        pulse_start(MDU_MULT, 32'h7FFFFFFF, 32'h00000003);
        repeat (19) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        model_hi = '0;
        model_lo = '0;
        total_cnt++;
        if ({busy, done, we_hi, we_lo, hi, lo} !== '0)
            $display("FAIL reset_mid_outputs got %h want 0", {busy, done, we_hi, we_lo, hi, lo});
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || we_hi || we_lo || busy) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_mid_no_write got %0d want 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul_div();
        test_mthi_busy();
        test_illegal_hold();
        test_cancel();
        test_reset_mid();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drained got %0d want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
